// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host-to-device command sequencer: inhibit, request-to-send, 11-bit
// transmit with ACK check, then reception and checking of the device reply.
`timescale 1ns/1ps
module ps2_cmd_ctrl #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic       iCLK_50,
  input  logic       iRST,
  input  logic [7:0] iCMD_DATA,
  input  logic       iCMD_VALID,
  output logic       oCMD_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       oCLK_OE,
  output logic       oDAT_OE,
  output logic       oRX_BLOCK,
  output logic       oDONE,
  output logic       oERR,
  output logic [1:0] oERR_CODE,
  output logic [7:0] oRESP
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_INHIBIT  = 3'd1;
  localparam logic [2:0] S_REQ      = 3'd2;
  localparam logic [2:0] S_TX       = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;
  localparam logic [2:0] S_WAITIDLE = 3'd5;
  localparam logic [2:0] S_RX       = 3'd6;
  localparam logic [2:0] S_FINISH   = 3'd7;

  localparam logic [1:0] E_OK      = 2'd0;
  localparam logic [1:0] E_TIMEOUT = 2'd1;
  localparam logic [1:0] E_NOACK   = 2'd2;
  localparam logic [1:0] E_FRAME   = 2'd3;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       tx_sh_q, tx_sh_d;
  logic             tx_oe_q, tx_oe_d;
  logic [9:0]       rx_sh_q, rx_sh_d;
  logic             idle_q, idle_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       resp_q, resp_d;
  logic [2:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;

  logic             fall, clk_s, dat_s, watch, timeout, rx_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic [10:0]      rx_word;

  // [0] first sync flop, [1] synchronized level, [2] previous synchronized level
  assign clk_s   = clk_sync_q[1];
  assign dat_s   = dat_sync_q[1];
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign cnt_inc = cnt_q + 1'b1;
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYC));
  assign watch   = (state_q == S_REQ) || (state_q == S_TX) || (state_q == S_ACK) ||
                   (state_q == S_WAITIDLE) || (state_q == S_RX);

  // Frame as it stands once the current fall is included: [0] start ... [10] stop
  assign rx_word = {dat_s, rx_sh_q};
  assign rx_ok   = ~rx_word[0] & rx_word[10] & (^rx_word[9:1]);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    tx_oe_d = tx_oe_q;
    rx_sh_d = rx_sh_q;
    idle_d  = idle_q;
    code_d  = code_q;
    resp_d  = resp_q;

    if (watch) cnt_d = fall ? '0 : cnt_inc;

    case (state_q)
      S_IDLE: begin
        if (iCMD_VALID) begin
          tx_sh_d = {1'b1, ~^iCMD_DATA, iCMD_DATA};
          cnt_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REQ: begin
        tx_oe_d = 1'b1;
        bit_d   = '0;
        state_d = S_TX;
      end
      S_TX: begin
        if (fall) begin
          tx_oe_d = ~tx_sh_q[0];
          tx_sh_d = {1'b0, tx_sh_q[9:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 4'd9) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (!dat_s) begin
            idle_d  = 1'b0;
            state_d = S_WAITIDLE;
          end else begin
            code_d  = E_NOACK;
            state_d = S_FINISH;
          end
        end
      end
      S_WAITIDLE: begin
        if (clk_s && dat_s) begin
          idle_d = 1'b1;
          if (idle_q) begin
            bit_d   = '0;
            state_d = S_RX;
          end
        end else begin
          idle_d = 1'b0;
        end
      end
      S_RX: begin
        if (fall) begin
          rx_sh_d = rx_word[10:1];
          bit_d   = bit_q + 1'b1;
          if (bit_q == 4'd10) begin
            code_d  = rx_ok ? E_OK : E_FRAME;
            resp_d  = rx_word[8:1];
            state_d = S_FINISH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A fall in the threshold cycle has already cleared the counter and wins.
    if (watch && !fall && timeout) begin
      code_d  = E_TIMEOUT;
      state_d = S_FINISH;
    end
  end

  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_sh_q    <= '0;
      tx_oe_q    <= 1'b0;
      rx_sh_q    <= '0;
      idle_q     <= 1'b0;
      code_q     <= E_OK;
      resp_q     <= '0;
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_oe_q    <= tx_oe_d;
      rx_sh_q    <= rx_sh_d;
      idle_q     <= idle_d;
      code_q     <= code_d;
      resp_q     <= resp_d;
      clk_sync_q <= {clk_sync_q[1:0], PS2_CLK_IN};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT_IN};
    end
  end

  // Pin enables decode from state so reset and FINISH release the bus at once.
  assign oCMD_READY = (state_q == S_IDLE);
  assign oRX_BLOCK  = (state_q != S_IDLE);
  assign oCLK_OE    = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign oDAT_OE    = (state_q == S_REQ) || ((state_q == S_TX) && tx_oe_q);
  assign oDONE      = (state_q == S_FINISH);
  assign oERR       = (code_q != E_OK);
  assign oERR_CODE  = code_q;
  assign oRESP      = resp_q;

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl: a behavioural PS/2 device on wired-AND
// pins, a vector table of complete commands, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_ps2_cmd_ctrl;

  localparam int INH = 1000;
  localparam int TMO = 3000;
  localparam int H   = 8;

  logic       iCLK_50 = 1'b0;
  logic       iRST = 1'b1;
  logic [7:0] iCMD_DATA = 8'h00;
  logic       iCMD_VALID = 1'b0;
  logic       oCMD_READY, oCLK_OE, oDAT_OE, oRX_BLOCK, oDONE, oERR;
  logic [1:0] oERR_CODE;
  logic [7:0] oRESP;
  logic       dev_clk = 1'b0;
  logic       dev_dat = 1'b0;
  logic       PS2_CLK_IN, PS2_DAT_IN;

  assign PS2_CLK_IN = ~(oCLK_OE | dev_clk);
  assign PS2_DAT_IN = ~(oDAT_OE | dev_dat);

  ps2_cmd_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .CNT_W(20)) dut (
    .iCLK_50(iCLK_50), .iRST(iRST), .iCMD_DATA(iCMD_DATA), .iCMD_VALID(iCMD_VALID),
    .oCMD_READY(oCMD_READY), .PS2_CLK_IN(PS2_CLK_IN), .PS2_DAT_IN(PS2_DAT_IN),
    .oCLK_OE(oCLK_OE), .oDAT_OE(oDAT_OE), .oRX_BLOCK(oRX_BLOCK), .oDONE(oDONE),
    .oERR(oERR), .oERR_CODE(oERR_CODE), .oRESP(oRESP)
  );

  always #10 iCLK_50 = ~iCLK_50;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle
  int cyc = 0, inh_cnt = 0, req_cnt = 0, req_cyc = 0, done_cnt = 0, done_cyc = 0;
  int run = 0, last_run = 0;
  logic       d_err = 1'b0, d_clk_oe = 1'b0, d_dat_oe = 1'b0;
  logic [1:0] d_code = 2'd0;
  logic [7:0] d_resp = 8'h00;

  always @(negedge iCLK_50) begin
    cyc++;
    if (oCLK_OE && !oDAT_OE) inh_cnt++;
    if (oCLK_OE && oDAT_OE) begin
      req_cnt++;
      req_cyc = cyc;
    end
    if (oDONE) begin
      done_cnt++;
      done_cyc = cyc;
      d_err    = oERR;
      d_code   = oERR_CODE;
      d_resp   = oRESP;
      d_clk_oe = oCLK_OE;
      d_dat_oe = oDAT_OE;
    end
    if (oCMD_READY) run++;
    else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge iCLK_50);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge iCLK_50);
    check("ready_before_cmd", 32'(oCMD_READY), 32'd1);
    iCMD_DATA  = b;
    iCMD_VALID = 1'b1;
    @(negedge iCLK_50);
    iCMD_VALID = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int bound);
    int n = 0;
    while (n < bound && done_cnt == prev) begin
      @(negedge iCLK_50);
      #1;
      n++;
    end
    check("done_seen", 32'(done_cnt), 32'(prev + 1));
  endtask

  // Device side: clocks the host frame in, ACKs (or not), then replies.
  // stop_after > 0 abandons the session right after that many falls.
  task automatic dev_session(input logic ack_ok, input logic [7:0] rb, input logic bad_par,
                             input logic bad_stop, input int stop_after,
                             output logic [10:0] smp);
    int n = 0;
    logic [10:0] frame;
    smp = '0;
    while (n < INH + 100 && !(!oCLK_OE && oDAT_OE)) begin
      @(negedge iCLK_50);
      n++;
    end
    check("dev_start_seen", 32'(!oCLK_OE && oDAT_OE), 32'd1);
    wait_cyc(H);
    smp[0] = PS2_DAT_IN;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b1;
      wait_cyc(H);
      dev_clk = 1'b0;
      if (i == stop_after) return;
      smp[i] = PS2_DAT_IN;
      wait_cyc(H);
    end
    dev_dat = ack_ok;
    wait_cyc(H);
    dev_clk = 1'b1;
    wait_cyc(H);
    dev_clk = 1'b0;
    wait_cyc(1);
    dev_dat = 1'b0;
    if (!ack_ok) return;
    wait_cyc(4 * H);
    frame = {~bad_stop, (~^rb) ^ bad_par, rb, 1'b0};
    for (int j = 0; j <= 10; j++) begin
      dev_dat = ~frame[j];
      wait_cyc(4);
      dev_clk = 1'b1;
      wait_cyc(H);
      dev_clk = 1'b0;
      wait_cyc(4);
    end
    dev_dat = 1'b0;
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       ack;
    logic [7:0] rb;
    logic       bad_par;
    logic       bad_stop;
    logic       exp_par;
    logic [1:0] exp_code;
    logic [7:0] exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic run_entry(input vec_t v);
    int d0 = done_cnt;
    int inh0 = inh_cnt;
    int req0 = req_cnt;
    logic [10:0] smp;
    send_cmd(v.cmd);
    dev_session(v.ack, v.rb, v.bad_par, v.bad_stop, 0, smp);
    wait_done(d0, 300);
    check("tx_frame", 32'(smp), 32'({1'b1, v.exp_par, v.cmd, 1'b0}));
    check("err_code", 32'(d_code), 32'(v.exp_code));
    check("err_flag", 32'(d_err), 32'(v.exp_code != 2'd0));
    check("resp", 32'(d_resp), 32'(v.exp_resp));
    check("inhibit_cycles", 32'(inh_cnt - inh0), 32'(INH));
    check("req_cycles", 32'(req_cnt - req0), 32'd1);
    wait_cyc(2);
    #1;
    check("single_done", 32'(done_cnt), 32'(d0 + 1));
    check("rx_block_after", 32'(oRX_BLOCK), 32'd0);
  endtask

  initial begin
    #(80000 * 20);
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation bound exceeded");
  end

  initial begin
    logic [10:0] smp;
    int d0, n;

    //           cmd    ack   rb    bpar  bstop par   code  resp
    vecs[0] = '{8'hF4, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b0, 2'd0, 8'hFA};
    vecs[1] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd2, 8'hFA};
    vecs[2] = '{8'h55, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00};
    vecs[3] = '{8'h01, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 2'd0, 8'hEE};
    vecs[4] = '{8'hFF, 1'b1, 8'hFA, 1'b1, 1'b0, 1'b1, 2'd3, 8'hFA};
    vecs[5] = '{8'h3C, 1'b1, 8'hFA, 1'b0, 1'b1, 1'b1, 2'd3, 8'hFA};

    wait_cyc(3);
    check("rst_clk_oe", 32'(oCLK_OE), 32'd0);
    check("rst_dat_oe", 32'(oDAT_OE), 32'd0);
    check("rst_done", 32'(oDONE), 32'd0);
    check("rst_err", 32'(oERR), 32'd0);
    check("rst_code", 32'(oERR_CODE), 32'd0);
    check("rst_resp", 32'(oRESP), 32'd0);
    check("rst_rx_block", 32'(oRX_BLOCK), 32'd0);
    check("rst_ready", 32'(oCMD_READY), 32'd1);
    iRST = 1'b0;
    wait_cyc(3);

    for (int i = 0; i < 6; i++) run_entry(vecs[i]);

    // Device never clocks: watchdog fires TMO cycles after REQ entry.
    d0 = done_cnt;
    send_cmd(8'hED);
    wait_done(d0, INH + TMO + 50);
    check("timeout_latency", 32'(done_cyc - req_cyc), 32'(TMO));
    check("timeout_code", 32'(d_code), 32'd1);
    check("timeout_err", 32'(d_err), 32'd1);
    check("timeout_resp_kept", 32'(d_resp), 32'hFA);
    check("timeout_clk_released", 32'(d_clk_oe), 32'd0);
    check("timeout_dat_released", 32'(d_dat_oe), 32'd0);
    wait_cyc(2);

    // Reset after fall 4 of a transmit (d3 of 0xF4 is 0, so data is driven).
    d0 = done_cnt;
    send_cmd(8'hF4);
    dev_session(1'b1, 8'hFA, 1'b0, 1'b0, 4, smp);
    wait_cyc(1);
    check("pre_rst_dat_oe", 32'(oDAT_OE), 32'd1);
    #3 iRST = 1'b1;
    #1;
    check("async_rst_clk_oe", 32'(oCLK_OE), 32'd0);
    check("async_rst_dat_oe", 32'(oDAT_OE), 32'd0);
    check("async_rst_rx_block", 32'(oRX_BLOCK), 32'd0);
    check("async_rst_resp", 32'(oRESP), 32'd0);
    wait_cyc(3);
    iRST = 1'b0;
    wait_cyc(3);
    #1;
    check("rst_no_done", 32'(done_cnt), 32'(d0));
    check("post_rst_ready", 32'(oCMD_READY), 32'd1);
    run_entry(vecs[0]);

    // iCMD_VALID held across three commands: one IDLE cycle between them.
    d0 = done_cnt;
    @(negedge iCLK_50);
    iCMD_DATA  = 8'hF4;
    iCMD_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n < 20 && oCMD_READY) begin
        @(negedge iCLK_50);
        #1;
        n++;
      end
      check("b2b_accepted", 32'(oCMD_READY), 32'd0);
      if (k > 0) check("b2b_ready_gap", 32'(last_run), 32'd1);
      if (k == 2) iCMD_VALID = 1'b0;
      dev_session(1'b1, 8'hFA, 1'b0, 1'b0, 0, smp);
      wait_done(d0 + k, 300);
      check("b2b_frame", 32'(smp), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
      check("b2b_code", 32'(d_code), 32'd0);
      check("b2b_resp", 32'(d_resp), 32'hFA);
    end
    wait_cyc(20);
    #1;
    check("b2b_done_count", 32'(done_cnt), 32'(d0 + 3));
    check("b2b_idle_ready", 32'(oCMD_READY), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_ctrl.md
Name: ps2_cmd_ctrl

Overview:
Host-to-device command sequencer for the PS/2 keyboard port.
- Accepts one command byte from system logic and runs the PS/2 host request-to-send sequence: clock inhibit, start, data, parity and stop.
- Checks the device ACK bit, then receives and checks the device's one-byte response (normally 0xFA).
- Owns the open-drain drive-low enables for PS2_CLK/PS2_DAT.
- Asserts a block flag so the scancode receiver ignores traffic while a command is in flight.

Parameters:
INHIBIT_CYC, 5000, cycles PS2_CLK is held low before the request (100 us at 50 MHz)
TIMEOUT_CYC, 1000000, maximum cycles between consecutive PS/2 clock falling edges in any bus state (20 ms)
CNT_W, 20, width of the shared inhibit/watchdog counter; must hold max(INHIBIT_CYC, TIMEOUT_CYC)

Ports:
iCLK_50  in  1  system clock, 50 MHz
iRST  in  1  asynchronous active-high reset
iCMD_DATA  in  8  command byte, sampled on accept
iCMD_VALID  in  1  command request
oCMD_READY  out  1  high only in IDLE; accept = iCMD_VALID & oCMD_READY
PS2_CLK_IN  in  1  raw PS2_CLK pin level
PS2_DAT_IN  in  1  raw PS2_DAT pin level
oCLK_OE  out  1  1 = drive PS2_CLK low; top level releases the pin to 'z when 0
oDAT_OE  out  1  1 = drive PS2_DAT low
oRX_BLOCK  out  1  high in every state except IDLE
oDONE  out  1  one-cycle pulse at the end of each accepted command
oERR  out  1  valid with oDONE; 1 = failure
oERR_CODE  out  2  valid with oDONE: 0 ok, 1 timeout, 2 no ACK, 3 response frame/parity error
oRESP  out  8  response byte, valid with oDONE; holds its value until the next oDONE

Behaviour:
Reset values (immediate, asynchronous):
- oCLK_OE=0, oDAT_OE=0; the bus is released in the same instant as reset.
- oDONE=0, oERR=0, oERR_CODE=0, oRESP=0x00, oRX_BLOCK=0, oCMD_READY=1.
- State IDLE; counters and synchronizers cleared to idle-high.

Input sampling:
- Two-flop synchronizers on PS2_CLK_IN and PS2_DAT_IN.
- "fall" = synced clock previous 1, current 0; one-cycle strobe.
- Data is sampled from the synced data flop in the fall cycle.

Parity: odd over 8 data bits; parity bit = ~^data.

States:
- IDLE: oCMD_READY=1. On accept, latch byte, compute parity, clear counter -> INHIBIT. iCMD_VALID while not IDLE is ignored; no queueing.
- INHIBIT: oCLK_OE=1 for exactly INHIBIT_CYC cycles -> REQ.
- REQ: one cycle with oCLK_OE=1, oDAT_OE=1 (start bit 0). Next cycle oCLK_OE=0 -> TX.
- TX: bit index 0..9. On each fall, drive the next bit, with oDAT_OE = ~bit, registered 1 cycle after fall:
  - falls 1-8: d0..d7, LSB first
  - fall 9: parity
  - fall 10: stop, oDAT_OE=0
  - The start bit stays driven until fall 1.
- ACK: on fall 11, synced data 0 -> WAITIDLE; data 1 -> finish with code 2.
- WAITIDLE: wait until synced clock=1 and data=1 for 2 consecutive cycles -> RX.
- RX: capture 11 bits on 11 falls, LSB first: start, d0..d7, parity, stop. After fall 11, check start=0, stop=1, odd parity.
  - All pass: code 0.
  - Any fail: code 3. oRESP is still loaded with the captured d0..d7.
- FINISH: one cycle; oDONE=1, oERR=(code!=0), and oERR_CODE/oRESP updated. Then -> IDLE, reachable again the next cycle.

Watchdog:
- Counter cleared on entering REQ and on every fall.
- In REQ/TX/ACK/WAITIDLE/RX, reaching TIMEOUT_CYC -> FINISH with code 1.
- oCLK_OE/oDAT_OE deassert in the same cycle FINISH is entered.

Boundaries:
- A fall in the same cycle as the timeout threshold: the fall wins and the counter clears.
- oRESP keeps its previous value on codes 1 and 2.
- Reset mid-command aborts with no oDONE pulse.

Test Plan:
1. Send 0xF4 to a device model that ACKs and replies 0xFA -> oCLK_OE high exactly 5000 cycles; device-sampled bits 0,0,0,1,0,1,1,1,1, parity 0, stop 1; single oDONE with oERR=0, oERR_CODE=0, oRESP=0xFA; oRX_BLOCK low after oDONE.
2. Send 0xED with the device never clocking -> oDONE exactly TIMEOUT_CYC cycles after REQ entry, oERR_CODE=1; bus released; oRESP unchanged from test 1 (0xFA).
3. Send 0x00 with the model holding data high at fall 11 -> parity bit driven 1, oERR_CODE=2, no response capture.
4. Model replies 0xFA with parity bit 0 -> oERR_CODE=3, oRESP=0xFA; a stop bit of 0 also gives code 3.
5. Assert iRST during TX after fall 4 -> oCLK_OE/oDAT_OE low immediately, asynchronously; no oDONE; after release oCMD_READY=1 and a new 0xF4 completes as in test 1.
6. Hold iCMD_VALID high for 3 command durations with a constant byte -> commands are back-to-back with oCMD_READY high exactly 1 cycle between them; no command is dropped mid-frame.
